// File: rtl/mp64_mul_arb.sv
// rtl/mp64_mul_arb.sv - round-robin arbiter/sequencer sharing one mp64_mul among NREQ requesters
module mp64_mul_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_signed,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [127:0]         rsp_result,
    output logic                 mul_start,
    output logic [63:0]          mul_a,
    output logic [63:0]          mul_b,
    output logic                 mul_signed,
    input  logic [127:0]         mul_result,
    input  logic                 mul_done,
    input  logic                 mul_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [63:0]     mul_a_q, mul_a_d;
    logic [63:0]     mul_b_q, mul_b_d;
    logic            mul_signed_q, mul_signed_d;
    logic [127:0]    rsp_result_q, rsp_result_d;

    // Per-requester operand views so the winner can be selected by index.
    logic [63:0]     a_arr [NREQ];
    logic [63:0]     b_arr [NREQ];

    logic            pick_valid;
    logic [IDW-1:0]  pick_id;
    int              scan_idx;
    logic            grant_now;
    logic            rsp_ack;

    // Slice the flat operand buses into per-requester words.
    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign a_arr[i] = req_a[i*64 +: 64];
        assign b_arr[i] = req_b[i*64 +: 64];
    end

    // Round-robin pick: first valid requester after last_grant, wrapping modulo NREQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        scan_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = (int'(last_grant_q) + k) % NREQ;
            if (!pick_valid && req_valid[IDW'(scan_idx)]) begin
                pick_valid = 1'b1;
                pick_id    = IDW'(scan_idx);
            end
        end
    end

    // A grant happens only from IDLE while the multiplier is free.
    assign grant_now = (state_q == S_IDLE) && pick_valid && !mul_busy;

    // Only the owner's rsp_ready can complete the response.
    assign rsp_ack = rsp_ready[grant_id_q];

    // Per-requester handshake outputs; req_ready is held low while reset is asserted.
    for (genvar i = 0; i < NREQ; i++) begin : g_chan
        assign req_ready[i] = rst_n && grant_now && (pick_id == IDW'(i));
        assign rsp_valid[i] = (state_q == S_RESP) && (grant_id_q == IDW'(i));
    end

    // Next-state and datapath capture for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        rsp_result_d = rsp_result_q;
        case (state_q)
            S_IDLE: begin
                if (grant_now) begin
                    grant_id_d   = pick_id;
                    mul_a_d      = a_arr[pick_id];
                    mul_b_d      = b_arr[pick_id];
                    mul_signed_d = req_signed[pick_id];
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    rsp_result_d = mul_result;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ack) begin
                    last_grant_d = grant_id_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            grant_id_q   <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign mul_start  = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_signed = mul_signed_q;
    assign grant_id   = grant_id_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_mp64_mul_arb.sv
// tb/tb_mp64_mul_arb.sv - self-checking bench for mp64_mul_arb with scoreboard and multiplier model
module tb_mp64_mul_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [64*NREQ-1:0]  req_a;
    logic [64*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_signed;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [127:0]        rsp_result;
    logic                mul_start;
    logic [63:0]         mul_a;
    logic [63:0]         mul_b;
    logic                mul_signed;
    logic [127:0]        mul_result;
    logic                mul_done;
    logic                mul_busy;
    logic [IDW-1:0]      grant_id;
    logic                busy;

    mp64_mul_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_signed (mul_signed),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .mul_busy   (mul_busy),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [127:0] res;
    } rsp_t;

    int           total = 0;
    int           bad   = 0;
    logic [63:0]  op_a [NREQ];
    logic [63:0]  op_b [NREQ];
    logic         op_s [NREQ];
    int           rem  [NREQ];
    int           exp_grant [$];
    rsp_t         exp_rsp [$];
    int           mdl_cnt = 0;
    logic [127:0] mdl_prod = '0;
    logic         s_start, s_busy, s_ms;
    logic [63:0]  s_ma, s_mb;
    logic [NREQ-1:0] s_rv, s_rdy;
    logic [127:0] s_res;
    logic         prev_hs = 1'b0;
    logic [63:0]  g_a, g_b;
    logic         g_s;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic signed [127:0] sa, sb;
        if (s) begin
            sa = {{64{a[63]}}, a};
            sb = {{64{b[63]}}, b};
            return sa * sb;
        end
        return {64'b0, a} * {64'b0, b};
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*64 +: 64] = op_a[i];
            req_b[i*64 +: 64] = op_b[i];
            req_signed[i]     = op_s[i];
        end
    endtask

    task automatic post(input int i, input logic [63:0] a, input logic [63:0] b, input logic s, input int n);
        op_a[i] = a;
        op_b[i] = b;
        op_s[i] = s;
        rem[i]  = n;
        req_valid[i] = 1'b1;
        drive();
    endtask

    // One clock: sample and check at negedge, then advance requesters and multiplier model after posedge.
    task automatic step();
        logic [NREQ-1:0] hs, acc;
        int   g, eg;
        rsp_t e;
        logic [127:0] one;
        @(negedge clk);
        s_start = mul_start; s_busy = busy; s_rv = rsp_valid; s_rdy = req_ready; s_res = rsp_result;
        s_ma = mul_a; s_mb = mul_b; s_ms = mul_signed;
        hs  = req_valid & req_ready;
        acc = rsp_valid & rsp_ready;
        check("start_after_grant", mul_start, prev_hs);
        if (mul_start) begin
            check("mul_a", mul_a, g_a);
            check("mul_b", mul_b, g_b);
            check("mul_signed", mul_signed, g_s);
        end
        check("ready_gate", (req_ready != 0) && (busy || mul_busy), 0);
        g = -1;
        if (hs != 0) begin
            check("ready_onehot", $countones(req_ready), 1);
            for (int i = 0; i < NREQ; i++) if (hs[i]) g = i;
            eg = (exp_grant.size() > 0) ? exp_grant.pop_front() : -1;
            check("grant_order", g, eg);
            g_a = op_a[g]; g_b = op_b[g]; g_s = op_s[g];
        end
        prev_hs = (hs != 0);
        if (acc != 0) begin
            if (exp_rsp.size() > 0) begin
                e = exp_rsp.pop_front();
                one = 128'd1;
                check("rsp_owner", rsp_valid, one << e.id);
                check("rsp_result", rsp_result, e.res);
            end else begin
                check("rsp_unexpected", rsp_valid, 0);
            end
        end else if (rsp_valid != 0) begin
            check("rsp_pending_expected", exp_rsp.size() > 0, 1);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                rem[i]--;
                if (rem[i] <= 0) req_valid[i] = 1'b0;
            end
        end
        mul_done = 1'b0;
        if (s_start) begin
            mdl_cnt  = 4;
            mul_busy = 1'b1;
            mdl_prod = prod(s_ma, s_mb, s_ms);
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                mul_done   = 1'b1;
                mul_result = mdl_prod;
                mul_busy   = 1'b0;
            end
        end
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while ((exp_grant.size() > 0 || exp_rsp.size() > 0 || busy || req_valid != 0) && n < max) begin
            step();
            n++;
        end
        check("drain_timeout", n < max, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
        check({tag, "_mul_signed"}, mul_signed, 0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        logic [127:0] held;
        rst_n = 1'b0;
        rsp_ready = '1;
        mul_done = 1'b0;
        mul_busy = 1'b0;
        mul_result = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 64'(i + 100); op_b[i] = 64'd3; op_s[i] = 1'b1; rem[i] = 0;
        end
        drive();
        req_valid = '1;
        #3;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        req_valid = '0;
        rst_n = 1'b1;

        // Single unsigned request from requester 0.
        post(0, 64'd7, 64'd6, 1'b0, 1);
        exp_grant.push_back(0);
        exp_rsp.push_back('{0, 128'd42});
        #1;
        check("t1_ready_comb", req_ready, 4'b0001);
        run_until_idle(50);

        // Signed -1 * 5 from requester 2.
        post(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 1);
        exp_grant.push_back(2);
        exp_rsp.push_back('{2, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB}});
        run_until_idle(50);

        // Response backpressure on requester 1 while requester 3 waits.
        rsp_ready = 4'b1101;
        post(1, 64'd9, 64'd9, 1'b0, 1);
        exp_grant.push_back(1);
        exp_rsp.push_back('{1, 128'd81});
        n = 0;
        s_rv = '0;
        while (s_rv != 4'b0010 && n < 40) begin
            step();
            n++;
        end
        check("bp_reach_resp", s_rv, 4'b0010);
        held = s_res;
        check("bp_result", held, 128'd81);
        post(3, 64'd11, 64'd3, 1'b0, 1);
        exp_grant.push_back(3);
        exp_rsp.push_back('{3, 128'd33});
        for (int c = 0; c < 6; c++) begin
            step();
            check("bp_rsp_valid", s_rv, 4'b0010);
            check("bp_rsp_stable", s_res, held);
            check("bp_no_start", s_start, 0);
            check("bp_no_ready", s_rdy, 0);
        end
        rsp_ready = '1;
        run_until_idle(60);

        // All four requesters contend for two ops each.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                exp_grant.push_back(i);
                exp_rsp.push_back('{i, 128'((i + 1) * 10)});
            end
        end
        for (int i = 0; i < NREQ; i++) post(i, 64'(i + 1), 64'd10, 1'b0, 2);
        run_until_idle(200);

        // Reset during WAIT aborts; next grant waits for the multiplier to go idle.
        post(0, 64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 1);
        exp_grant.push_back(0);
        n = 0;
        while (mdl_cnt != 2 && n < 20) begin
            step();
            n++;
        end
        check("rst_in_wait", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        step();
        rst_n = 1'b1;
        post(0, 64'd3, 64'd4, 1'b0, 1);
        exp_grant.push_back(0);
        exp_rsp.push_back('{0, 128'd12});
        #1;
        check("rst_busy_blocks", req_ready, 0);
        run_until_idle(60);

        // Stray done with nothing in flight.
        mul_result = 128'hDEAD_BEEF;
        mul_done = 1'b1;
        step();
        repeat (3) step();
        check("spur_busy", s_busy, 0);
        check("spur_rsp", s_rv, 0);
        check("spur_busy_now", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
